nios_system_pio_in_irq: RTL and testbench

- Parametrised Avalon-MM slave input PIO for board switches and keys; successor to the fixed 18-bit read-only switch port.
- Adds an input synchroniser, a per-bit debounce filter, a per-bit edge-capture register with write-1-to-clear, an interrupt mask and a level IRQ to the Nios II.
- Sits between the pad inputs and the system interconnect.

---
 rtl/nios_system_pio_in_irq.sv | 114 +++++++++++
 tb/tb_nios_system_pio_in_irq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nios_system_pio_in_irq.sv
// Avalon-MM input PIO: synchroniser, per-bit debounce, edge capture with
// write-1-to-clear, interrupt mask and level IRQ for switches and keys.
module nios_system_pio_in_irq #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES > 0) begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt [WIDTH];

    // Accept the new level on the cycle the count would reach the limit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stable <= '0;
        for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end else begin : g_bypass
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stable <= '0;
      else          stable <= sync;
    end
  end

  assign rise  = stable & ~stable_d;
  assign fall  = ~stable & stable_d;
  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_det = rise | fall;
    if (EDGE_TYPE == 0)      edge_det = rise;
    else if (EDGE_TYPE == 1) edge_det = fall;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // A new edge in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d    <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      stable_d    <= stable;
      edgecapture <= (edgecapture & ~clr) | edge_det;
      readdata    <= rd_mux;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Scoreboard bench for nios_system_pio_in_irq: three instances cover
// rising-edge, any-edge and 4-bit configurations with a short debounce.
module tb_nios_system_pio_in_irq;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             rst2_n;
  logic [1:0]       address;
  logic [2:0]       cs;
  logic             write_n;
  logic [31:0]      writedata;
  logic [17:0]      in0;
  logic [17:0]      in1;
  logic [3:0]       in2;
  logic [2:0][31:0] rdata;
  logic [2:0]       irqs;
  logic             rd_req;
  logic             rd_vld;

  exp_t rd_q [$];
  exp_t irq_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nios_system_pio_in_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rdata[0]), .irq(irqs[0]));

  nios_system_pio_in_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
    .clk(clk), .reset_n(rst_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rdata[1]), .irq(irqs[1]));

  nios_system_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u2 (
    .clk(clk), .reset_n(rst2_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rdata[2]), .irq(irqs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: reads complete one edge after the request; irq checks are immediate.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rd_vld) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_underflow: read completed with no expectation queued");
        end else begin
          e = rd_q.pop_front();
          if (rdata[e.sel] !== e.val) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, rdata[e.sel], e.val);
          end
        end
      end
      while (irq_q.size() > 0) begin
        e = irq_q.pop_front();
        n_cmp++;
        if (irqs[e.sel] !== e.val[0]) begin
          n_bad++;
          $display("FAIL %s: irq got %b expected %b", e.name, irqs[e.sel], e.val[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int s, input logic [1:0] a, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = s; e.val = v; e.name = nm;
    address = a;
    rd_req  = 1'b1;
    rd_q.push_back(e);
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic ck_irq(input int s, input logic v, input string nm);
    exp_t e;
    e.sel = s; e.val = {31'd0, v}; e.name = nm;
    irq_q.push_back(e);
  endtask

  task automatic wr(input int s, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    cs        = 3'b000;
    cs[s]     = 1'b1;
    write_n   = 1'b0;
    tick(1);
    cs      = 3'b000;
    write_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    address = 2'd0; cs = 3'b000; write_n = 1'b1; writedata = '0;
    in0 = '0; in1 = '0; in2 = 4'hF; rd_req = 1'b0;
    tick(3);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick(1);

    ck_irq(0, 1'b0, "rst_irq");
    rd(0, 2'd0, 32'h0, "rst_data");
    rd(0, 2'd2, 32'h0, "rst_mask");
    rd(0, 2'd3, 32'h0, "rst_edge");

    in0 = 18'h00008; tick(3); in0 = '0; tick(10);
    rd(0, 2'd0, 32'h0, "glitch_data");
    rd(0, 2'd3, 32'h0, "glitch_edge");

    in0 = 18'h00008; tick(10);
    rd(0, 2'd0, 32'h8, "rise_data");
    rd(0, 2'd3, 32'h8, "rise_edge");
    ck_irq(0, 1'b0, "rise_irq_masked");
    rd(0, 2'd1, 32'h0, "rsvd_zero");
    wr(0, 2'd0, 32'h0003FFFF);
    rd(0, 2'd0, 32'h8, "data_wr_ignored");

    wr(0, 2'd2, 32'h8);
    ck_irq(0, 1'b1, "irq_after_mask");
    rd(0, 2'd2, 32'h8, "mask_read");
    wr(0, 2'd3, 32'h8);
    ck_irq(0, 1'b0, "irq_after_clr");
    rd(0, 2'd3, 32'h0, "edge_after_clr");

    // Edge on bit 5 lands in edgecapture on the 7th edge after the pad change.
    in0 = 18'h00028; tick(6);
    wr(0, 2'd3, 32'h20);
    rd(0, 2'd3, 32'h20, "collide_set_wins");
    rd(0, 2'd0, 32'h28, "collide_data");
    ck_irq(0, 1'b0, "irq_unmasked_bit");

    in0 = 18'h00020; tick(10);
    rd(0, 2'd3, 32'h20, "rise_mode_ignores_fall");
    rd(0, 2'd0, 32'h20, "fall_data");

    in1 = 18'h00001; tick(10);
    rd(1, 2'd3, 32'h1, "any_rise");
    wr(1, 2'd3, 32'h1);
    rd(1, 2'd3, 32'h0, "any_clr");
    in1 = 18'h00000; tick(10);
    rd(1, 2'd3, 32'h1, "any_fall");
    rd(1, 2'd0, 32'h0, "any_data");

    rd(2, 2'd0, 32'h0000000F, "w4_data");
    rd(2, 2'd3, 32'h0000000F, "w4_edge");
    wr(2, 2'd2, 32'hFFFFFFFF);
    rd(2, 2'd2, 32'h0000000F, "w4_mask_trunc");
    ck_irq(2, 1'b1, "w4_irq");

    in2 = 4'h0; tick(3);
    rst2_n = 1'b0;
    ck_irq(2, 1'b0, "rst_irq_immediate");
    rd(2, 2'd0, 32'h0, "rst_mid_data");
    rd(2, 2'd2, 32'h0, "rst_mid_mask");
    rd(2, 2'd3, 32'h0, "rst_mid_edge");
    rst2_n = 1'b1;
    tick(12);
    rd(2, 2'd0, 32'h0, "post_rst_data");
    rd(2, 2'd3, 32'h0, "post_rst_edge");
    ck_irq(2, 1'b0, "post_rst_irq");

    tick(3);
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending reads %0d irq checks %0d expected 0 and 0", rd_q.size(), irq_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
